register_io_deskew: RTL
=======================

# register_io_deskew

Multi-lane I/O register bank with per-lane programmable deskew delay. Each lane samples `data_in` in an I/O-packed input register, delays it by 0..`MAX_DELAY` enabled cycles, and drives `data_out` from an I/O-packed output register. Lane delays are written through a valid/ready configuration port. A settle counter flags when output data is trustworthy after reset or after any delay change. It sits at the FPGA pin boundary of parallel source-synchronous buses whose lanes need skew trimming.

## Interface
- `LANE_COUNT`, 1: number of independent lanes, ≥1.
- `WORD_WIDTH`, 1: bits per lane, ≥1.
- `MAX_DELAY`, 7: largest per-lane extra delay in cycles, ≥1.
- `RESET_VALUE`, 0: `WORD_WIDTH`-bit value loaded into every data register on `clear`.
- Derived: `DELAY_WIDTH` = clog2(`MAX_DELAY`+1). `LANE_WIDTH` = max(1, clog2(`LANE_COUNT`)).
- `clock`  in  1  sole clock. One clock; reset is synchronous and active-high.
- `clear`  in  1  synchronous active-high reset. Overrides everything, including `clock_enable`.
- `clock_enable`  in  1  advances the data path and settle counter when 1.
- `data_in`  in  `LANE_COUNT*WORD_WIDTH`  lane i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
- `data_out`  out  `LANE_COUNT*WORD_WIDTH`  same packing as `data_in`.
- `data_out_valid`  out  1  is 1 when every lane's pipeline holds post-settle data.
- `delay_set_valid`  in  1  config request.
- `delay_set_ready`  out  1  config port can accept a request.
- `delay_set_lane`  in  `LANE_WIDTH`  target lane.
- `delay_set_value`  in  `DELAY_WIDTH`  requested extra delay.

## Operation
- Per-lane data path: input register (carries `useioff`/`IOB` attributes, no `KEEP`/`DONT_TOUCH`), then a `MAX_DELAY`-deep shift line, then a tap mux selected by `delay[lane]`, then an output register (same attributes).
- Tap 0 is the input register output. Tap d is that output after d shift stages.
- The input register, shift line, and output register update only when `clock_enable`=1.
- Reset values: `data_out`, input registers, and shift registers = `RESET_VALUE`. All `delay[lane]`=0. `data_out_valid`=0. `delay_set_ready`=0. State=SETTLE. Counter=`MAX_DELAY`+2.
- States:
  - SETTLE: `delay_set_ready`=0, `data_out_valid`=0. Each edge with `clock_enable`=1 decrements the counter. At the edge where the counter goes 1→0, move to RUN.
  - RUN: `delay_set_ready`=1, `data_out_valid`=1.
- Handshake: a request is accepted at an edge where `delay_set_valid`=1, `delay_set_ready`=1, and `clear`=0.
  - Acceptance is independent of `clock_enable`.
  - On acceptance: `delay[delay_set_lane]` is loaded, state goes to SETTLE, and the counter loads `MAX_DELAY`+2.
- `delay_set_value` > `MAX_DELAY` saturates to `MAX_DELAY`.
- `delay_set_lane` ≥ `LANE_COUNT`: the request is accepted (the handshake completes) but ignored. No delay changes and state stays RUN.
- `clear` asserted mid-SETTLE or together with a request: full reset, and the request is dropped.
- `clear` alone while `clock_enable`=0: still resets everything.
- Output data is not gated by `data_out_valid`. Downstream logic must qualify it.

## Timing
- Latency for lane i: a word on `data_in` at enabled edge n appears on `data_out` after enabled edge n+1+`delay[i]`. Minimum is 2 enabled edges, maximum `MAX_DELAY`+2.
- `clock_enable`=0 cycles stretch latency 1:1. Data is held, never lost or duplicated.
- Delay change takes effect on the tap mux at the acceptance edge. Output may glitch to an older or newer word during SETTLE.
- Handshake at edge k: `delay_set_ready` and `data_out_valid` read 0 from k+1. They return to 1 after `MAX_DELAY`+2 further enabled edges.
- After `clear` deasserts, `data_out_valid` rises after `MAX_DELAY`+2 enabled edges.
- At most one request is accepted per settle period. Back-to-back requests wait for RUN.

## Test plan
- Reset (LANE_COUNT=4, WORD_WIDTH=8, MAX_DELAY=7, RESET_VALUE=8'hA5): hold `clear` 3 cycles -> `data_out`=32'hA5A5A5A5, valid=0, ready=0. Valid and ready rise exactly 9 enabled edges after `clear` drops.
- Latency with all delays 0: drive counting pattern 0x00,0x01,… on lane 0 -> `data_out` lane 0 lags by exactly 2 edges. Set lane 2 to 5 -> lane 2 lags by 7 edges, and ready returns after 9 enabled edges.
- Saturation and invalid lane (LANE_COUNT=3):
  - Request lane 1, value 7 with MAX_DELAY=5 -> lane 1 latency 7.
  - Request lane 3 -> handshake completes, ready stays 1, valid stays 1, all latencies unchanged.
- `clock_enable` stall: drop enable for 4 cycles mid-stream and mid-SETTLE -> `data_out` frozen, counter frozen. The sequence resumes with no word lost or repeated, and valid rises 4 cycles later.
- `clear` mid-SETTLE with simultaneous `delay_set_valid`=1 -> all delays 0, request dropped, outputs equal `RESET_VALUE`, and the full 9-edge settle restarts.

Source files
------------

// File: rtl/register_io_deskew.sv
`default_nettype none
// ============================================================================
// Module   : register_io_deskew
// Purpose  : Pin-boundary register bank with per-lane programmable deskew
//            delay and a settle flag qualifying output data.
// Revision : 1.0
// ============================================================================
module register_io_deskew #(
    parameter int                    LANE_COUNT  = 1,
    parameter int                    WORD_WIDTH  = 1,
    parameter int                    MAX_DELAY   = 7,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0,
    localparam int DELAY_WIDTH = $clog2(MAX_DELAY + 1),
    localparam int LANE_WIDTH  = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1
) (
    input  logic                             clock,
    input  logic                             clear,
    input  logic                             clock_enable,
    input  logic [LANE_COUNT*WORD_WIDTH-1:0] data_in,
    output logic [LANE_COUNT*WORD_WIDTH-1:0] data_out,
    output logic                             data_out_valid,
    input  logic                             delay_set_valid,
    output logic                             delay_set_ready,
    input  logic [LANE_WIDTH-1:0]            delay_set_lane,
    input  logic [DELAY_WIDTH-1:0]           delay_set_value
);

    localparam int                     CNT_WIDTH     = $clog2(MAX_DELAY + 3);
    localparam logic [CNT_WIDTH-1:0]   SETTLE_CYCLES = CNT_WIDTH'(MAX_DELAY + 2);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE       = CNT_WIDTH'(1);
    localparam logic [DELAY_WIDTH-1:0] DELAY_MAX     = DELAY_WIDTH'(MAX_DELAY);

    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    logic [0:0]             state_q;
    logic [0:0]             state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic [DELAY_WIDTH-1:0] delay_q [LANE_COUNT];
    logic                   lane_ok;
    logic                   accept;
    logic [DELAY_WIDTH-1:0] value_sat;

    assign lane_ok   = ({1'b0, delay_set_lane} < (LANE_WIDTH + 1)'(LANE_COUNT));
    assign accept    = delay_set_valid && delay_set_ready && !clear;
    assign value_sat = (delay_set_value > DELAY_MAX) ? DELAY_MAX : delay_set_value;

    // ------------------------------------------------------------------
    // Settle FSM: state register, next-state logic, output decode
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_SETTLE;
            cnt_q   <= SETTLE_CYCLES;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SETTLE: begin
                if (clock_enable) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Requests to a nonexistent lane complete the handshake only.
                if (accept && lane_ok) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_CYCLES;
                end
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = SETTLE_CYCLES;
            end
        endcase
    end

    always_comb begin
        delay_set_ready = 1'b0;
        data_out_valid  = 1'b0;
        if (state_q == ST_RUN) begin
            delay_set_ready = 1'b1;
            data_out_valid  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane delay selection
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < LANE_COUNT; i++) begin
                delay_q[i] <= '0;
            end
        end else if (accept && lane_ok) begin
            for (int i = 0; i < LANE_COUNT; i++) begin
                if (delay_set_lane == LANE_WIDTH'(i)) begin
                    delay_q[i] <= value_sat;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-lane data path: IOB input reg, shift line, tap mux, IOB output reg
    // ------------------------------------------------------------------
    for (genvar i = 0; i < LANE_COUNT; i++) begin : g_lane
        (* useioff = 1, IOB = "TRUE" *) logic [WORD_WIDTH-1:0] in_q;
        (* useioff = 1, IOB = "TRUE" *) logic [WORD_WIDTH-1:0] out_q;
        logic [WORD_WIDTH-1:0] shift_q [MAX_DELAY];
        logic [WORD_WIDTH-1:0] tap_sel;

        always_comb begin
            tap_sel = in_q;
            for (int k = 0; k < MAX_DELAY; k++) begin
                if (delay_q[i] == DELAY_WIDTH'(k + 1)) begin
                    tap_sel = shift_q[k];
                end
            end
        end

        always_ff @(posedge clock) begin
            if (clear) begin
                in_q  <= RESET_VALUE;
                out_q <= RESET_VALUE;
                for (int k = 0; k < MAX_DELAY; k++) begin
                    shift_q[k] <= RESET_VALUE;
                end
            end else if (clock_enable) begin
                in_q       <= data_in[i*WORD_WIDTH +: WORD_WIDTH];
                out_q      <= tap_sel;
                shift_q[0] <= in_q;
                for (int k = 1; k < MAX_DELAY; k++) begin
                    shift_q[k] <= shift_q[k-1];
                end
            end
        end

        assign data_out[i*WORD_WIDTH +: WORD_WIDTH] = out_q;
    end

endmodule
`default_nettype wire
